// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/response handshake bundle for seq_alu
interface seq_alu_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_less;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_less, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_less, out_illegal
  );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle RV32IM-style ALU with valid/ready handshake and flush
// Iterative mul/div (codes 10-17) exists only when SEQ_ALU_MULDIV_EN is defined.
module seq_alu #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_accept;
  logic            w_load_alu;
  logic            w_illegal;
  logic            w_less;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu_res;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_less;
  logic            r_illegal;

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_result  = r_result;
  assign bus.out_zero    = r_zero;
  assign bus.out_less    = r_less;
  assign bus.out_illegal = r_illegal;

  assign w_accept = bus.in_valid && (r_state == S_IDLE) && !flush;
  assign w_shamt  = bus.in_b[SHW-1:0];
  assign w_less   = $signed(bus.in_a) < $signed(bus.in_b);

  always_comb begin
    w_alu_res = '0;
    case (bus.in_op)
      5'd0:    w_alu_res = bus.in_a + bus.in_b;
      5'd1:    w_alu_res = bus.in_a - bus.in_b;
      5'd2:    w_alu_res = bus.in_a & bus.in_b;
      5'd3:    w_alu_res = bus.in_a | bus.in_b;
      5'd4:    w_alu_res = bus.in_a ^ bus.in_b;
      5'd5:    w_alu_res = bus.in_a << w_shamt;
      5'd6:    w_alu_res = bus.in_a >> w_shamt;
      5'd7:    w_alu_res = $signed(bus.in_a) >>> w_shamt;
      5'd8:    w_alu_res = {{(XLEN-1){1'b0}}, w_less};
      5'd9:    w_alu_res = {{(XLEN-1){1'b0}}, (bus.in_a < bus.in_b)};
      default: w_alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [4:0]   OP_MUL   = 5'd10;
  localparam logic [4:0]   OP_DIV   = 5'd14;
  localparam logic [4:0]   OP_DIVU  = 5'd15;
  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  logic [SHW:0]      r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_mb;
  logic [4:0]        r_op;
  logic              r_a_neg;
  logic              r_b_neg;
  logic              r_b_zero;
  logic              r_less_md;
  logic              w_is_md;
  logic              w_start;
  logic              w_finish;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_shift;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_fix;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  logic [XLEN-1:0]   w_md_res;

  assign w_is_md    = (bus.in_op >= 5'd10) && (bus.in_op <= 5'd17);
  assign w_illegal  = (bus.in_op >= 5'd18);
  assign w_start    = w_accept && w_is_md;
  assign w_load_alu = w_accept && !w_is_md;
  assign w_finish   = (r_state == S_BUSY) && (r_cnt == CNT_ONE) && !flush;

  // Datapath works on magnitudes; the sign is reapplied on the final step.
  assign w_a_sgn = bus.in_a[XLEN-1] && (bus.in_op inside {5'd11, 5'd12, 5'd14, 5'd16});
  assign w_b_sgn = bus.in_b[XLEN-1] && (bus.in_op inside {5'd11, 5'd14, 5'd16});
  assign w_mag_a = w_a_sgn ? -bus.in_a : bus.in_a;
  assign w_mag_b = w_b_sgn ? -bus.in_b : bus.in_b;

  // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mb} : '0);
    w_shift = r_acc[2*XLEN-1:XLEN-1];
    w_diff  = w_shift - {1'b0, r_mb};
    w_step  = '0;
    if (r_op >= OP_DIV) begin
      if (w_diff[XLEN]) w_step = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      else              w_step = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_step = {w_sum, r_acc[XLEN-1:1]};
    end
  end

  always_comb begin
    w_fix    = (r_a_neg ^ r_b_neg) ? -w_step : w_step;
    w_q      = w_step[XLEN-1:0];
    w_r      = w_step[2*XLEN-1:XLEN];
    w_md_res = '0;
    if (r_op == OP_MUL)
      w_md_res = w_fix[XLEN-1:0];
    else if (r_op < OP_DIV)
      w_md_res = w_fix[2*XLEN-1:XLEN];
    else if (r_op <= OP_DIVU)
      w_md_res = r_b_zero ? '1 : ((r_a_neg ^ r_b_neg) ? -w_q : w_q);
    else
      w_md_res = r_a_neg ? -w_r : w_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mb      <= '0;
      r_op      <= '0;
      r_a_neg   <= 1'b0;
      r_b_neg   <= 1'b0;
      r_b_zero  <= 1'b0;
      r_less_md <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt     <= CNT_LOAD;
      r_acc     <= {{XLEN{1'b0}}, w_mag_a};
      r_mb      <= w_mag_b;
      r_op      <= bus.in_op;
      r_a_neg   <= w_a_sgn;
      r_b_neg   <= w_b_sgn;
      r_b_zero  <= (bus.in_b == '0);
      r_less_md <= w_less;
    end else if (r_state == S_BUSY) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end
`else
  assign w_illegal  = (bus.in_op >= 5'd10);
  assign w_load_alu = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef SEQ_ALU_MULDIV_EN
      S_IDLE:  if (w_accept) w_state_nxt = w_is_md ? S_BUSY : S_DONE;
      S_BUSY:  if (r_cnt == CNT_ONE) w_state_nxt = S_DONE;
`else
      S_IDLE:  if (w_accept) w_state_nxt = S_DONE;
`endif
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_less    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_load_alu) begin
      r_result  <= w_alu_res;
      r_zero    <= (w_alu_res == '0);
      r_less    <= w_less;
      r_illegal <= w_illegal;
`ifdef SEQ_ALU_MULDIV_EN
    end else if (w_finish) begin
      r_result  <= w_md_res;
      r_zero    <= (w_md_res == '0);
      r_less    <= r_less_md;
      r_illegal <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic reference model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  seq_alu_if #(.XLEN(32)) bus ();

  seq_alu #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic is_illegal(input logic [4:0] op);
`ifdef SEQ_ALU_MULDIV_EN
    return op >= 5'd18;
`else
    return op >= 5'd10;
`endif
  endfunction

  function automatic int exp_lat(input logic [4:0] op);
`ifdef SEQ_ALU_MULDIV_EN
    if (op >= 5'd10 && op <= 5'd17) return 33;
`endif
    return 1;
  endfunction

  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        up;
    logic signed [31:0] sq;
    logic [4:0]         sh;
    sh = b[4:0];
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    up = {32'b0, a} * {32'b0, b};
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a & b;
      5'd3: return a | b;
      5'd4: return a ^ b;
      5'd5: return a << sh;
      5'd6: return a >> sh;
      5'd7: begin sq = $signed(a) >>> sh; return sq; end
      5'd8: return {31'b0, $signed(a) < $signed(b)};
      5'd9: return {31'b0, a < b};
`ifdef SEQ_ALU_MULDIV_EN
      5'd10: return up[31:0];
      5'd11: begin sp = sa * sb; return sp[63:32]; end
      5'd12: begin sp = sa * $signed({32'b0, b}); return sp[63:32]; end
      5'd13: return up[63:32];
      5'd14: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        sq = $signed(a) / $signed(b);
        return sq;
      end
      5'd15: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      5'd16: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        sq = $signed(a) % $signed(b);
        return sq;
      end
      5'd17: return (b == 32'h0) ? a : a % b;
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    int          lat;
    logic [31:0] er;
    logic [31:0] held;
    er = model_res(op, a, b);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 5'($urandom);
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat(op)));
    chk($sformatf("result op%0d a=%h b=%h", op, a, b), bus.out_result, er);
    chk($sformatf("zero op%0d", op), 32'(bus.out_zero), 32'(er == 32'h0));
    chk($sformatf("less op%0d", op), 32'(bus.out_less), 32'($signed(a) < $signed(b)));
    chk($sformatf("illegal op%0d", op), 32'(bus.out_illegal), 32'(is_illegal(op)));
    if (hold > 0) begin
      held = bus.out_result;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_result", bus.out_result, held);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("in_ready_after", 32'(bus.in_ready), 32'd1);
    chk("valid_after", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic flush_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    int seen;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    chk("pre_flush_valid", 32'(bus.out_valid), 32'(k + 1 >= exp_lat(op)));
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_result"}, bus.out_result, 32'h0);
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'd0);
    chk({tag, "_less"}, 32'(bus.out_less), 32'd0);
    chk({tag, "_illegal"}, 32'(bus.out_illegal), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] a, b;
    bus.in_valid  = 1'b0;
    bus.in_op     = 5'd0;
    bus.in_a      = 32'h0;
    bus.in_b      = 32'h0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(5'd0, 32'h7FFFFFFF, 32'h00000001, 0);
    run_op(5'd1, 32'd5, 32'd5, 0);
    run_op(5'd7, 32'h80000000, 32'h00000024, 0);
    run_op(5'd9, 32'd1, 32'hFFFFFFFF, 0);
    run_op(5'd5, 32'h00000003, 32'hFFFFFFE1, 0);
    run_op(5'd8, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op(5'd14, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(5'd16, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op(5'd15, 32'd7, 32'd0, 0);
    run_op(5'd17, 32'd7, 32'd0, 0);
    run_op(5'd14, 32'hFFFFFFF9, 32'd0, 0);
    run_op(5'd16, 32'hFFFFFFF9, 32'd0, 0);
    run_op(5'd14, 32'hFFFFFFF9, 32'd2, 0);
    run_op(5'd16, 32'hFFFFFFF9, 32'd2, 0);
    run_op(5'd25, 32'h12345678, 32'h9ABCDEF0, 0);

    run_op(5'd0, 32'h12345678, 32'h11111111, 10);

    flush_op(5'd15, 32'hDEADBEEF, 32'd3, 11);

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 5'd0;
    flush        = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    chk("flush_accept_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_accept_valid", 32'(bus.out_valid), 32'd0);

    run_op(5'd1, 32'd9, 32'd9, 0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = 5'd10;
    bus.in_a      = 32'hFFFFFFFD;
    bus.in_b      = 32'd7;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 19));
      if (i % 8 == 7) op = 5'($urandom_range(18, 31));
      a = pick();
      b = pick();
      run_op(op, a, b, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
